// File: rtl/ysyx_23060077_ifu_rsp.sv
// Instruction-fetch response engine: fixed-latency burst reads from a preloadable
// word memory, with range/alignment errors reported as a single error beat.
module ysyx_23060077_ifu_rsp #(
   parameter int          LATENCY = 2,
   parameter int          DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h2000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid_i,
   input  logic [31:0]              req_addr_i,
   input  logic [7:0]               req_len_i,
   output logic                     rsp_ready_o,
   output logic [31:0]              rsp_data_o,
   output logic                     rsp_last_o,
   output logic                     rsp_err_o,
   input  logic                     init_we_i,
   input  logic [$clog2(DEPTH)-1:0] init_idx_i,
   input  logic [31:0]              init_data_i
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] BEAT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [32:0] LIMIT  = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   logic [1:0]  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] addr_reg, addr_next;
   logic [7:0]  len_reg, len_next;
   logic [7:0]  beat_reg, beat_next;
   logic        err_reg, err_next;

   logic        rsp_ready_reg, rsp_last_reg, rsp_err_reg;
   logic [31:0] rsp_data_reg;

   logic [31:0] mem [DEPTH];

   logic [32:0]   req_end;
   logic          req_err;
   logic          beat_en;
   logic [31:0]   rd_addr;
   logic [7:0]    rd_k;
   logic          rd_err, rd_last;
   logic [AW-1:0] rd_idx;

   // 33-bit end address so a burst near 4 GiB cannot wrap past the limit check
   assign req_end = {1'b0, req_addr_i} + {23'd0, req_len_i, 2'b00} + 33'd4;
   assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BASE) || (req_end > LIMIT);

   assign rd_idx = AW'((rd_addr - BASE) >> 2) + AW'(rd_k);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      len_next   = len_reg;
      beat_next  = beat_reg;
      err_next   = err_reg;
      beat_en    = 1'b0;
      rd_addr    = addr_reg;
      rd_k       = beat_reg;
      rd_err     = err_reg;
      rd_last    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               addr_next = req_addr_i;
               len_next  = req_len_i;
               err_next  = req_err;
               beat_next = 8'd0;
               cnt_next  = LAT_M1;
               if (LATENCY == 1) begin
                  state_next = BEAT;
                  beat_en    = 1'b1;
                  rd_addr    = req_addr_i;
                  rd_k       = 8'd0;
                  rd_err     = req_err;
                  rd_last    = req_err || (req_len_i == 8'd0);
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            // the first beat is loaded on the edge where the count reaches zero
            cnt_next = cnt_reg - 4'd1;
            if (cnt_next == 4'd0) begin
               state_next = BEAT;
               beat_en    = 1'b1;
               rd_k       = 8'd0;
               rd_last    = err_reg || (len_reg == 8'd0);
            end
         end
         BEAT: begin
            if (rsp_last_reg) begin
               state_next = DONE;
            end else begin
               beat_en   = 1'b1;
               rd_k      = beat_reg + 8'd1;
               beat_next = beat_reg + 8'd1;
               rd_last   = (rd_k == len_reg);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         addr_reg  <= 32'd0;
         len_reg   <= 8'd0;
         beat_reg  <= 8'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         len_reg   <= len_next;
         beat_reg  <= beat_next;
         err_reg   <= err_next;
      end
   end

   // preload is independent of reset so memory survives it
   always_ff @(posedge clk) begin
      if (init_we_i)
         mem[init_idx_i] <= init_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_ready_reg <= 1'b0;
         rsp_last_reg  <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_data_reg  <= 32'd0;
      end else begin
         rsp_ready_reg <= beat_en;
         rsp_last_reg  <= beat_en && rd_last;
         rsp_err_reg   <= beat_en && rd_err;
         rsp_data_reg  <= (beat_en && !rd_err) ? mem[rd_idx] : 32'd0;
      end
   end

   assign rsp_ready_o = rsp_ready_reg;
   assign rsp_data_o  = rsp_data_reg;
   assign rsp_last_o  = rsp_last_reg;
   assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_ysyx_23060077_ifu_rsp.sv
// Scoreboard bench: one LATENCY=2 and one LATENCY=1 instance, expected beats queued
// with their cycle when a burst is driven and matched as the DUT emits them.
module tb_ysyx_23060077_ifu_rsp;
   localparam int          LAT0  = 2;
   localparam int          LAT1  = 1;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h2000_0000;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        err;
      int          cyc;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1;
   logic [31:0] a0, a1;
   logic [7:0]  l0, l1;
   logic        init_we;
   logic [9:0]  init_idx;
   logic [31:0] init_data;
   logic        rdy0, rdy1, last0, last1, err0, err1;
   logic [31:0] dat0, dat1;

   int    cyc = 0;
   int    checks_total = 0;
   int    checks_passed = 0;
   logic  mon_en = 1'b0;
   beat_t q0[$];
   beat_t q1[$];
   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_23060077_ifu_rsp #(.LATENCY(LAT0), .DEPTH(DEPTH), .BASE(BASE)) u2 (
      .clk(clk), .reset(rst), .req_valid_i(v0), .req_addr_i(a0), .req_len_i(l0),
      .rsp_ready_o(rdy0), .rsp_data_o(dat0), .rsp_last_o(last0), .rsp_err_o(err0),
      .init_we_i(init_we), .init_idx_i(init_idx), .init_data_i(init_data));

   ysyx_23060077_ifu_rsp #(.LATENCY(LAT1), .DEPTH(DEPTH), .BASE(BASE)) u1 (
      .clk(clk), .reset(rst), .req_valid_i(v1), .req_addr_i(a1), .req_len_i(l1),
      .rsp_ready_o(rdy1), .rsp_data_o(dat1), .rsp_last_o(last1), .rsp_err_o(err1),
      .init_we_i(init_we), .init_idx_i(init_idx), .init_data_i(init_data));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s @cycle %0d: got %0h required %0h", tag, cyc, got, exp);
   endtask

   function automatic logic model_err(input logic [31:0] a, input int len);
      longint unsigned s, lim;
      s   = {32'd0, a} + 4 * (len + 1);
      lim = {32'd0, BASE} + 4 * DEPTH;
      return (a[1:0] != 2'b00) || (a < BASE) || (s > lim);
   endfunction

   task automatic mon(input int sel, input logic rdy, input logic [31:0] d,
                      input logic l, input logic e);
      beat_t b;
      logic  exp_rdy;
      string p;
      p = (sel == 0) ? "u2" : "u1";
      exp_rdy = 1'b0;
      b = '{data: 32'd0, last: 1'b0, err: 1'b0, cyc: 0};
      if (sel == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin exp_rdy = 1'b1; b = q0.pop_front(); end
      if (sel == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin exp_rdy = 1'b1; b = q1.pop_front(); end
      check_eq({p, ".ready"}, 64'(rdy), 64'(exp_rdy));
      if (rdy && exp_rdy) begin
         check_eq({p, ".data"}, 64'(d), 64'(b.data));
         check_eq({p, ".last"}, 64'(l), 64'(b.last));
         check_eq({p, ".err"},  64'(e), 64'(b.err));
      end else if (!rdy) begin
         check_eq({p, ".idle"}, 64'({d, l, e}), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, rdy0, dat0, last0, err0);
         mon(1, rdy1, dat1, last1, err1);
      end
   end

   task automatic set_req(input int sel, input logic v, input logic [31:0] a, input logic [7:0] l);
      if (sel == 0) begin v0 = v; a0 = a; l0 = l; end
      else          begin v1 = v; a1 = a; l1 = l; end
   endtask

   // mode 0 normal, 1 drop valid and scramble addr/len after capture,
   // 2 reset during beat 2, 3 overwrite word 5 on the edge that reads beat 5
   task automatic burst(input int sel, input logic [31:0] addr, input int len, input int mode);
      int    lat, nb, t, last_cyc, stop_c, base_idx;
      logic  e;
      beat_t b;
      lat = (sel == 0) ? LAT0 : LAT1;
      e   = model_err(addr, len);
      nb  = e ? 1 : len + 1;
      t   = cyc;
      base_idx = int'((addr - BASE) >> 2);
      for (int k = 0; k < nb; k++) begin
         if (!(mode == 2 && k > 2)) begin
            b.data = e ? 32'd0 : mdl[(base_idx + k) % DEPTH];
            b.last = (k == nb - 1);
            b.err  = e;
            b.cyc  = t + lat + k;
            if (sel == 0) q0.push_back(b); else q1.push_back(b);
         end
      end
      $display("burst u%0d addr=%h len=%0d mode=%0d err=%0b beats=%0d", 2 - sel, addr, len, mode, e, nb);
      last_cyc = t + lat + nb - 1;
      stop_c   = (mode == 2) ? t + lat + 2 : last_cyc + 1;
      set_req(sel, 1'b1, addr, 8'(len));
      for (int c = t; c <= stop_c; c++) begin
         if (mode == 1 && c == t + 1) set_req(sel, 1'b0, ~addr, ~8'(len));
         if (mode == 1 && c == t + 2) set_req(sel, 1'b1, addr ^ 32'h40, 8'd9);
         if (mode == 1 && c == t + 3) set_req(sel, 1'b0, ~addr, 8'd0);
         if (mode == 2 && c == t + lat + 2) rst = 1'b1;
         if (mode == 3 && c == t + lat + 4) begin
            init_we = 1'b1; init_idx = 10'd5; init_data = 32'h0000_AAAA;
         end
         if (mode == 3 && c == t + lat + 5) begin
            init_we = 1'b0; mdl[5] = 32'h0000_AAAA;
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      set_req(sel, 1'b0, 32'd0, 8'd0);
   endtask

   initial begin
      logic [31:0] v;
      rst = 1'b1; init_we = 1'b0; init_idx = '0; init_data = '0;
      set_req(0, 1'b0, 32'd0, 8'd0);
      set_req(1, 1'b0, 32'd0, 8'd0);
      @(posedge clk); #1;
      mon_en = 1'b1;
      // preload with reset still asserted
      for (int i = 0; i < DEPTH; i++) begin
         if (i < 4)       v = 32'(11 * (i + 1));
         else if (i == 5) v = 32'h0000_5555;
         else             v = {16'hC0DE, 16'(i)};
         init_we = 1'b1; init_idx = 10'(i); init_data = v; mdl[i] = v;
         @(posedge clk); #1;
      end
      init_we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      burst(0, BASE, 3, 0);
      burst(0, BASE + 32'd4, 0, 0);
      burst(0, BASE + 32'd2, 3, 0);
      burst(0, BASE + 32'(4 * (DEPTH - 1)), 1, 0);
      burst(0, 32'h1FFF_FFFC, 0, 0);
      burst(0, 32'hFFFF_FFFC, 3, 0);
      burst(0, BASE + 32'(4 * (DEPTH - 2)), 1, 0);
      burst(0, BASE + 32'h40, 7, 2);
      burst(0, BASE, 3, 0);
      burst(0, BASE, 7, 3);
      burst(0, BASE + 32'd20, 0, 0);
      burst(0, BASE + 32'd8, 4, 1);
      burst(1, BASE, 255, 0);
      burst(1, BASE + 32'd12, 2, 0);
      burst(1, BASE + 32'd3, 0, 0);
      burst(1, BASE + 32'd4, 1, 1);

      repeat (4) begin @(posedge clk); #1; end
      check_eq("drain", 64'(q0.size() + q1.size()), 64'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
